// File: rtl/btn_arb_pkg.sv
// -----------------------------------------------------------------------------
// btn_arb_pkg
// Shared constants for the button command arbiter: button count, ASCII command
// codes, FSM state encoding and the round-robin pick helper.
// Used by btn_cmd_arbiter and btn_repeat_gen.
// -----------------------------------------------------------------------------
package btn_arb_pkg;

    localparam int unsigned N_BTN = 4;

    // Button index order: 0=U, 1=D, 2=L, 3=R
    localparam logic [7:0] CODE_U = 8'h55;
    localparam logic [7:0] CODE_D = 8'h44;
    localparam logic [7:0] CODE_L = 8'h4C;
    localparam logic [7:0] CODE_R = 8'h52;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } grant_t;

    // First pending index at or after ptr, wrapping modulo N_BTN.
    function automatic grant_t rr_pick(input logic [N_BTN-1:0] pend,
                                       input logic [1:0]       ptr);
        grant_t     g;
        logic [1:0] k;
        g = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            k = ptr + i[1:0];
            if (!g.found && pend[k]) begin
                g.found = 1'b1;
                g.idx   = k;
            end
        end
        return g;
    endfunction

    function automatic logic [7:0] code_of(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = CODE_U;
            2'd1:    c = CODE_D;
            2'd2:    c = CODE_L;
            default: c = CODE_R;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_repeat_gen.sv
// -----------------------------------------------------------------------------
// btn_repeat_gen
// Auto-repeat event generator for one button. After a press pulse, while the
// held level stays high, emits a one-cycle event REP_DELAY cycles after the
// pulse and then one every REP_PERIOD cycles. A low level restarts the timing.
// The event is aligned to the same cycle position as a press pulse so it can be
// merged with the pulse input directly.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   pulse  - one-cycle press pulse
//   level  - debounced held level
//   rep    - one-cycle repeat event
// -----------------------------------------------------------------------------
module btn_repeat_gen #(
    parameter int unsigned REP_DELAY  = 50_000_000,
    parameter int unsigned REP_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse,
    input  logic level,
    output logic rep
);

    localparam int unsigned MAXV = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned CW   = $clog2(MAXV + 1);

    logic          armed;
    logic          phase;   // 0: waiting for first repeat, 1: periodic
    logic [CW-1:0] cnt;     // cycles since pulse / since last repeat
    logic [CW-1:0] target;

    always_comb begin
        target = phase ? CW'(REP_PERIOD) : CW'(REP_DELAY);
        rep    = armed && level && (cnt == target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            phase <= 1'b0;
            cnt   <= '0;
        end else if (!level) begin
            armed <= 1'b0;
            phase <= 1'b0;
            cnt   <= '0;
        end else if (pulse) begin
            armed <= 1'b1;
            phase <= 1'b0;
            cnt   <= CW'(1);
        end else if (armed) begin
            if (rep) begin
                phase <= 1'b1;
                cnt   <= CW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// btn_cmd_arbiter
// Collects button events (press pulses, plus auto-repeat events when the
// BTN_ARB_REPEAT_EN macro is defined) into per-button pending bits, grants them
// round-robin and offers one ASCII command at a time on a valid/ready port.
// Events arriving for a button that is already pending are dropped and counted.
// Input events pass through one register stage before reaching the pending
// bits, so a command is offered two edges after the edge sampling the pulse.
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   i_btn_pulse  - press pulses, bit0=U bit1=D bit2=L bit3=R
//   i_btn_level  - held levels (auto-repeat only; ignored otherwise)
//   o_cmd_valid  - command offered
//   i_cmd_ready  - downstream accepts
//   o_cmd_code   - ASCII command byte
//   o_cmd_id     - granted button index
//   o_drop       - one-cycle pulse when any event is lost
//   o_drop_cnt   - saturating lost-event count
// Build option: define BTN_ARB_REPEAT_EN to enable auto-repeat.
// -----------------------------------------------------------------------------
module btn_cmd_arbiter
    import btn_arb_pkg::*;
#(
    parameter int unsigned REP_DELAY  = 50_000_000,
    parameter int unsigned REP_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_btn_pulse,
    input  logic [3:0] i_btn_level,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic [7:0] o_cmd_code,
    output logic [1:0] o_cmd_id,
    output logic       o_drop,
    output logic [7:0] o_drop_cnt
);

    logic [N_BTN-1:0] rep_evt;
    logic [N_BTN-1:0] evt_q;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] grant_oh;
    logic [N_BTN-1:0] drop_vec;
    logic [0:0]       state;
    logic [1:0]       rr_ptr;
    grant_t           pick;
    logic             accept;
    logic             take;
    logic             grant_en;

`ifdef BTN_ARB_REPEAT_EN
    for (genvar b = 0; b < N_BTN; b++) begin : g_rep
        btn_repeat_gen #(
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD)
        ) u_rep (
            .clk  (clk),
            .rst_n(rst_n),
            .pulse(i_btn_pulse[b]),
            .level(i_btn_level[b]),
            .rep  (rep_evt[b])
        );
    end
`else
    logic unused_level;
    assign rep_evt      = '0;
    assign unused_level = ^{i_btn_level, REP_DELAY, REP_PERIOD};
`endif

    assign o_cmd_valid = (state == ST_VALID);

    always_comb begin
        pick     = rr_pick(pending, rr_ptr);
        accept   = (state == ST_VALID) && i_cmd_ready;
        // A new grant may be loaded from IDLE or on the accept edge (no bubble)
        take     = (state == ST_IDLE) || accept;
        grant_en = take && pick.found;
        grant_oh = '0;
        if (grant_en) begin
            grant_oh[pick.idx] = 1'b1;
        end
        // An event on a bit granted this cycle re-queues instead of dropping
        drop_vec = evt_q & pending & ~grant_oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q      <= '0;
            pending    <= '0;
            state      <= ST_IDLE;
            rr_ptr     <= 2'd0;
            o_cmd_code <= 8'h00;
            o_cmd_id   <= 2'd0;
            o_drop     <= 1'b0;
            o_drop_cnt <= 8'h00;
        end else begin
            evt_q   <= i_btn_pulse | rep_evt;
            pending <= (pending & ~grant_oh) | evt_q;
            o_drop  <= |drop_vec;
            if ((|drop_vec) && (o_drop_cnt != 8'hFF)) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
            if (grant_en) begin
                state      <= ST_VALID;
                o_cmd_code <= code_of(pick.idx);
                o_cmd_id   <= pick.idx;
                rr_ptr     <= pick.idx + 2'd1;
            end else if (accept) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule
